counter_ctrl: RTL and testbench

Command-driven sequencer for the board's free-running up-counter datapath. Adds the following to the counter:
- a prescaled count tick
- start/stop/clear/load control
- up/down direction and a programmable terminal value
- wrap or one-shot modes

Sits between debounced pushbutton/DIP-switch logic and the LED/7-segment display of count Q. Everything runs in a single clock domain.

---
 rtl/counter_ctrl_pkg.sv | 19 +
 rtl/counter_ctrl_tick_gen.sv | 40 ++++
 rtl/counter_ctrl.sv | 161 ++++++++++++++++
 tb/tb_counter_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared command codes and FSM state encodings for the counter sequencer.
package counter_ctrl_pkg;

  // Command codes carried on cmd; codes 5..7 are reserved and behave as NOP.
  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_CLEAR = 3'd3;
  localparam logic [2:0] CMD_LOAD  = 3'd4;

  // FSM state encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef logic [1:0] state_t;

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the step cycle.
// step is a decode of the count register so the parent can register the
// resulting Q update and tick in the same edge.
module tick_gen #(
  parameter int unsigned PRESCALE = 12000000,
  parameter int unsigned PS_W     = 24
) (
  input  logic Clock,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;

  assign step = en && (cnt_q == LAST);

  // Next prescaler value: clear wins, a step wraps to 0, otherwise count while
  // enabled and hold (freeze) while disabled.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (step) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + PS_W'(1);
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer around a prescaled up/down counter. Owns the
// IDLE/RUN/PAUSED/DONE FSM and the Q datapath; all outputs are registered.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 12000000,
  parameter int unsigned PS_W     = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir_down,
  input  logic             oneshot,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             running,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             ready_q;

  logic accept;
  logic ps_en, ps_clr, step;
  logic cmd_hit;

  assign accept = cmd_valid && ready_q;
  assign ps_en  = (state_q == ST_RUN);

  tick_gen #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_tick_gen (
    .Clock (Clock),
    .Reset (Reset),
    .en    (ps_en),
    .clr   (ps_clr),
    .step  (step)
  );

  // FSM and Q next-state: an effective command in RUN discards a coincident
  // step; otherwise a step applies the up/down terminal rule.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    ps_clr  = 1'b0;
    cmd_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_START: begin state_d = ST_RUN; ps_clr = 1'b1; end
            CMD_LOAD:  q_d = load_val;
            CMD_CLEAR: q_d = '0;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (accept) begin
          case (cmd)
            // Prescaler keeps its post-edge value; on a step cycle it wraps
            // to 0, so a STOP there freezes it at 0.
            CMD_STOP:  begin state_d = ST_PAUSED; cmd_hit = 1'b1; end
            CMD_CLEAR: begin q_d = '0;       ps_clr = 1'b1; cmd_hit = 1'b1; end
            CMD_LOAD:  begin q_d = load_val; ps_clr = 1'b1; cmd_hit = 1'b1; end
            default: ;
          endcase
        end
        if (step && !cmd_hit) begin
          tick_d = 1'b1;
          if (!dir_down) begin
            if (q_q >= limit) begin
              if (oneshot) state_d = ST_DONE;
              else         q_d     = '0;
            end else begin
              q_d = q_q + WIDTH'(1);
            end
          end else begin
            if (q_q == '0) begin
              if (oneshot) state_d = ST_DONE;
              else         q_d     = limit;
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
      end

      ST_PAUSED: begin
        if (accept) begin
          case (cmd)
            CMD_START: state_d = ST_RUN;
            CMD_CLEAR: begin state_d = ST_IDLE; q_d = '0; ps_clr = 1'b1; end
            CMD_LOAD:  q_d = load_val;
            default: ;
          endcase
        end
      end

      ST_DONE: begin
        if (accept) begin
          case (cmd)
            CMD_START: begin
              state_d = ST_RUN;
              q_d     = dir_down ? limit : '0;
              ps_clr  = 1'b1;
            end
            CMD_CLEAR: begin state_d = ST_IDLE; q_d = '0; end
            CMD_LOAD:  begin state_d = ST_IDLE; q_d = load_val; end
            CMD_STOP:  state_d = ST_IDLE;
            default: ;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // Register state, count and status outputs; reset aborts any pending step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      q_q       <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      done_q    <= done_d;
      ready_q   <= 1'b1;
    end
  end

  assign cmd_ready = ready_q;
  assign Q         = q_q;
  assign tick      = tick_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with WIDTH=4, PRESCALE=4.
module tb_counter_ctrl;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PS_W     = 4;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_START = 3'd1;
  localparam logic [2:0] C_STOP  = 3'd2;
  localparam logic [2:0] C_CLEAR = 3'd3;
  localparam logic [2:0] C_LOAD  = 3'd4;
  localparam logic [2:0] C_RSVD  = 3'd5;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             cmd_valid;
  logic [2:0]       cmd;
  logic             cmd_ready;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             dir_down;
  logic             oneshot;
  logic [WIDTH-1:0] Q;
  logic             tick;
  logic             running;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  counter_ctrl #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .load_val  (load_val),
    .limit     (limit),
    .dir_down  (dir_down),
    .oneshot   (oneshot),
    .Q         (Q),
    .tick      (tick),
    .running   (running),
    .done      (done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic clk1();
    @(posedge Clock);
    #1;
  endtask

  // Present a command for exactly one edge.
  task automatic send(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    clk1();
    cmd_valid = 1'b0;
    cmd       = C_NOP;
  endtask

  // From prescaler=0 in RUN: three quiet edges, then a step with Q=exp_q.
  task automatic wait_step(input string tag, input logic [WIDTH-1:0] exp_q);
    repeat (3) begin
      clk1();
      check({tag, "_quiet"}, 32'(tick), 32'd0);
    end
    clk1();
    check({tag, "_tick"}, 32'(tick), 32'd1);
    check({tag, "_q"}, 32'(Q), 32'(exp_q));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = C_NOP;
    load_val  = '0;
    limit     = '0;
    dir_down  = 1'b0;
    oneshot   = 1'b0;

    // 1. Reset held 3 cycles, then released.
    repeat (3) begin
      clk1();
      check("rst_ready", 32'(cmd_ready), 32'd0);
    end
    check("rst_q", 32'(Q), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    Reset = 1'b0;
    clk1();
    check("rel_ready", 32'(cmd_ready), 32'd1);
    check("rel_q", 32'(Q), 32'd0);

    // 2. Up, wrap, limit=5: 1,2,3,4,5,0,1.
    limit = 4'd5;
    send(C_START);
    check("t2_running", 32'(running), 32'd1);
    check("t2_q0", 32'(Q), 32'd0);
    wait_step("t2_s1", 4'd1);
    wait_step("t2_s2", 4'd2);
    wait_step("t2_s3", 4'd3);
    wait_step("t2_s4", 4'd4);
    wait_step("t2_s5", 4'd5);
    wait_step("t2_wrap", 4'd0);
    wait_step("t2_s1b", 4'd1);
    check("t2_running_end", 32'(running), 32'd1);

    // 3. Back to IDLE, LOAD 9, count down one-shot into DONE.
    send(C_STOP);
    check("t3_paused", 32'(running), 32'd0);
    send(C_CLEAR);
    check("t3_idle_q", 32'(Q), 32'd0);
    load_val = 4'd9;
    send(C_LOAD);
    check("t3_load_q", 32'(Q), 32'd9);
    check("t3_load_running", 32'(running), 32'd0);
    dir_down = 1'b1;
    oneshot  = 1'b1;
    send(C_START);
    for (int v = 8; v >= 0; v--) wait_step("t3_down", 4'(v));
    check("t3_pre_done", 32'(done), 32'd0);
    wait_step("t3_term", 4'd0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_done_running", 32'(running), 32'd0);
    clk1();
    check("t3_done_notick", 32'(tick), 32'd0);
    send(C_START);
    check("t3_restart_q", 32'(Q), 32'd5);
    check("t3_restart_running", 32'(running), 32'd1);
    check("t3_restart_done", 32'(done), 32'd0);

    // 4. STOP after 2 prescale cycles, idle 10, resume: tick 2 edges later.
    clk1();
    send(C_STOP);
    check("t4_paused", 32'(running), 32'd0);
    repeat (10) begin
      clk1();
      check("t4_paused_notick", 32'(tick), 32'd0);
    end
    check("t4_paused_q", 32'(Q), 32'd5);
    send(C_START);
    check("t4_resume_running", 32'(running), 32'd1);
    clk1();
    check("t4_resume_quiet", 32'(tick), 32'd0);
    clk1();
    check("t4_resume_tick", 32'(tick), 32'd1);
    check("t4_resume_q", 32'(Q), 32'd4);

    // 5. CLEAR on a step cycle with Q=3 (up): step discarded.
    wait_step("t5_q3", 4'd3);
    dir_down = 1'b0;
    oneshot  = 1'b0;
    repeat (3) clk1();
    send(C_CLEAR);
    check("t5_clr_q", 32'(Q), 32'd0);
    check("t5_clr_tick", 32'(tick), 32'd0);
    check("t5_clr_running", 32'(running), 32'd1);
    wait_step("t5_next", 4'd1);

    // 6. Reset mid-RUN with Q=7, prescaler=2; then a reserved command.
    limit    = 4'd9;
    load_val = 4'd7;
    send(C_LOAD);
    check("t6_load_q", 32'(Q), 32'd7);
    repeat (2) clk1();
    Reset = 1'b1;
    clk1();
    check("t6_rst_q", 32'(Q), 32'd0);
    check("t6_rst_running", 32'(running), 32'd0);
    check("t6_rst_ready", 32'(cmd_ready), 32'd0);
    Reset = 1'b0;
    clk1();
    check("t6_ready", 32'(cmd_ready), 32'd1);
    send(C_RSVD);
    check("t6_rsvd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) begin
      clk1();
      check("t6_rsvd_notick", 32'(tick), 32'd0);
    end
    check("t6_rsvd_running", 32'(running), 32'd0);
    check("t6_rsvd_q", 32'(Q), 32'd0);

    // limit=0, up, wrap: Q stays 0 but ticks on every step.
    limit = 4'd0;
    send(C_START);
    wait_step("lim0_a", 4'd0);
    wait_step("lim0_b", 4'd0);
    check("lim0_running", 32'(running), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
